// File: rtl/reg_fifo_periph_if.sv
// Register-bus bundle for reg_fifo_periph: data-phase address/strobes
// from the AHB slave stage, plus the read data and interrupt back.
interface reg_fifo_periph_if #(
    parameter int ADDRWIDTH = 12
);
    logic [ADDRWIDTH-1:0] addr;
    logic                 read_en;
    logic                 write_en;
    logic [3:0]           byte_strobe;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 irq;

    modport master (
        output addr, read_en, write_en, byte_strobe, wdata,
        input  rdata, irq
    );

    modport slave (
        input  addr, read_en, write_en, byte_strobe, wdata,
        output rdata, irq
    );
endinterface

// File: rtl/reg_fifo_periph.sv
// Register-mapped 8-entry FIFO peripheral: DATA push/pop, STATUS with sticky
// overflow/underflow (W1C), CTRL with enable, irq enable, threshold and flush.
module reg_fifo_periph #(
    parameter int ADDRWIDTH = 12,
    parameter int DEPTH     = 8
) (
    input  logic             hclk,
    input  logic             hreset,
    reg_fifo_periph_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_RSVD   = 2'd3
    } reg_sel_e;

    // NOTE: storage has no reset; the pointers alone define which entries are valid.
    logic [31:0]      mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             ovf_q,    ovf_d;
    logic             udf_q,    udf_d;
    logic             enable_q, enable_d;
    logic             irq_en_q, irq_en_d;
    logic [3:0]       thresh_q, thresh_d;
    logic             irq_q,    irq_d;

    reg_sel_e         sel;
    logic             wr_access;
    logic             data_wr, data_rd, status_wr, ctrl_wr;
    logic             empty, full;
    logic             push, pop, flush;
    logic             ovf_set, udf_set, ovf_clr, udf_clr;
    logic [31:0]      push_data;
    logic [31:0]      rdata_d;
    logic             unused_addr;

    // Only addr[3:2] selects a register; the rest of the address aliases.
    assign sel         = reg_sel_e'(bus.addr[3:2]);
    assign unused_addr = ^{bus.addr[ADDRWIDTH-1:4], bus.addr[1:0]};

    // A simultaneous read and write is treated as a read only.
    assign wr_access = bus.write_en & ~bus.read_en;
    assign data_wr   = wr_access   & (sel == REG_DATA);
    assign status_wr = wr_access   & (sel == REG_STATUS);
    assign ctrl_wr   = wr_access   & (sel == REG_CTRL) & bus.byte_strobe[0];
    assign data_rd   = bus.read_en & (sel == REG_DATA);

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_FULL);

    assign push    = data_wr & enable_q & ~full;
    assign ovf_set = data_wr & enable_q &  full;
    assign pop     = data_rd & ~empty;
    assign udf_set = data_rd &  empty;
    assign ovf_clr = status_wr & bus.byte_strobe[1] & bus.wdata[8];
    assign udf_clr = status_wr & bus.byte_strobe[1] & bus.wdata[9];
    assign flush   = ctrl_wr & bus.wdata[2];

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            push_data[8*b +: 8] = bus.byte_strobe[b] ? bus.wdata[8*b +: 8] : 8'h00;
        end
    end

    // Next-state logic; irq is computed from the post-update values.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end

        if (ctrl_wr) begin
            enable_d = bus.wdata[0];
            irq_en_d = bus.wdata[1];
            thresh_d = bus.wdata[7:4];
        end

        // Set wins over a same-cycle write-1-to-clear.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr);
        udf_d = udf_set | (udf_q & ~udf_clr);

        irq_d = irq_en_d & (ovf_d | udf_d |
                            ((thresh_d != 4'd0) & (count_d >= {1'b0, thresh_d})));
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            enable_q <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= 4'd0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            enable_q <= enable_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            irq_q    <= irq_d;
        end
    end

    // Writes under reset are blocked so an aborted transfer stores nothing.
    always_ff @(posedge hclk) begin
        if (push && !hreset) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (bus.read_en) begin
            case (sel)
                REG_DATA:   rdata_d = empty ? 32'h0 : mem_q[rd_ptr_q];
                REG_STATUS: rdata_d = {22'h0, udf_q, ovf_q, 2'b00, full, empty,
                                       {(4-CNT_W){1'b0}}, count_q};
                REG_CTRL:   rdata_d = {24'h0, thresh_q, 2'b00, irq_en_q, enable_q};
                default:    rdata_d = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_d;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_reg_fifo_periph.sv
// Directed self-checking bench for reg_fifo_periph: reset values, FIFO order,
// overflow/underflow flags, byte strobes, wrap, threshold irq, flush, async reset.
module tb_reg_fifo_periph;
    localparam logic [11:0] A_DATA   = 12'h000;
    localparam logic [11:0] A_STATUS = 12'h004;
    localparam logic [11:0] A_CTRL   = 12'h008;
    localparam logic [11:0] A_RSVD   = 12'h00C;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 hclk = ~hclk;

    reg_fifo_periph_if #(.ADDRWIDTH(12)) bus ();

    reg_fifo_periph #(.ADDRWIDTH(12), .DEPTH(8)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] bs);
        @(negedge hclk);
        bus.addr        = a;
        bus.wdata       = d;
        bus.byte_strobe = bs;
        bus.read_en     = 1'b0;
        bus.write_en    = 1'b1;
        @(posedge hclk);
        #1;
        bus.write_en    = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] d;
        @(negedge hclk);
        bus.addr     = a;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        #1;
        d = bus.rdata;
        check(tag, d, exp);
        @(posedge hclk);
        #1;
        bus.read_en  = 1'b0;
    endtask

    initial begin
        bus.addr        = '0;
        bus.wdata       = '0;
        bus.byte_strobe = '0;
        bus.read_en     = 1'b0;
        bus.write_en    = 1'b0;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        hreset = 1'b0;

        // Reset state
        check("rdata_idle", bus.rdata, 32'h0);
        read_check("rst_status", A_STATUS, 32'h0000_0010);
        read_check("rst_ctrl",   A_CTRL,   32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);

        // Fill, overflow, drain in order
        bus_write(A_CTRL, 32'h1, 4'b0001);
        for (int i = 0; i < 8; i++) bus_write(A_DATA, 32'hA1 + i, 4'hF);
        read_check("full_status", A_STATUS, 32'h0000_0028);
        bus_write(A_DATA, 32'hA9, 4'hF);
        read_check("ovf_status", A_STATUS, 32'h0000_0128);
        for (int i = 0; i < 8; i++) read_check($sformatf("pop_%0d", i), A_DATA, 32'hA1 + i);
        read_check("drained_status", A_STATUS, 32'h0000_0110);
        bus_write(A_STATUS, 32'h100, 4'b0001);
        read_check("w1c_no_strobe", A_STATUS, 32'h0000_0110);
        bus_write(A_STATUS, 32'h100, 4'b0010);
        read_check("ovf_cleared", A_STATUS, 32'h0000_0010);

        // Underflow
        read_check("empty_pop", A_DATA, 32'h0);
        read_check("udf_status", A_STATUS, 32'h0000_0210);
        bus_write(A_STATUS, 32'h200, 4'b0010);
        read_check("udf_cleared", A_STATUS, 32'h0000_0010);

        // Byte strobes
        bus_write(A_DATA, 32'h1122_3344, 4'b0101);
        read_check("bs_pop", A_DATA, 32'h0022_0044);

        // Interleaved push/pop across the pointer wrap
        bus_write(A_DATA, 32'hB00, 4'hF);
        for (int i = 0; i < 12; i++) begin
            bus_write(A_DATA, 32'hB01 + i, 4'hF);
            read_check($sformatf("wrap_pop_%0d", i), A_DATA, 32'hB00 + i);
        end
        read_check("wrap_last", A_DATA, 32'hB0C);
        read_check("wrap_status", A_STATUS, 32'h0000_0010);

        // Read and write together: read wins, no push, udf set
        @(negedge hclk);
        bus.addr        = A_DATA;
        bus.wdata       = 32'hDEAD;
        bus.byte_strobe = 4'hF;
        bus.read_en     = 1'b1;
        bus.write_en    = 1'b1;
        #1;
        check("rw_rdata", bus.rdata, 32'h0);
        @(posedge hclk);
        #1;
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        read_check("rw_status", A_STATUS, 32'h0000_0210);
        bus_write(A_STATUS, 32'h200, 4'b0010);

        // Reserved register and address aliasing
        bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
        read_check("rsvd_read", A_RSVD, 32'h0);
        read_check("alias_status", 12'hFF4, 32'h0000_0010);

        // Disabled FIFO ignores pushes, no overflow
        bus_write(A_CTRL, 32'h0, 4'b0001);
        bus_write(A_DATA, 32'h55, 4'hF);
        read_check("disabled_status", A_STATUS, 32'h0000_0010);

        // Threshold interrupt and flush
        bus_write(A_CTRL, 32'h33, 4'b0001);
        check("thr_irq_0", {31'h0, bus.irq}, 32'h0);
        bus_write(A_DATA, 32'hC1, 4'hF);
        check("thr_irq_1", {31'h0, bus.irq}, 32'h0);
        bus_write(A_DATA, 32'hC2, 4'hF);
        check("thr_irq_2", {31'h0, bus.irq}, 32'h0);
        bus_write(A_DATA, 32'hC3, 4'hF);
        check("thr_irq_3", {31'h0, bus.irq}, 32'h1);
        read_check("thr_pop", A_DATA, 32'hC1);
        check("thr_irq_pop", {31'h0, bus.irq}, 32'h0);
        bus_write(A_CTRL, 32'h37, 4'b0001);
        read_check("flush_status", A_STATUS, 32'h0000_0010);
        read_check("flush_ctrl", A_CTRL, 32'h0000_0033);

        // Async reset in the data phase of a DATA write
        bus_write(A_CTRL, 32'h13, 4'b0001);
        bus_write(A_DATA, 32'h77, 4'hF);
        check("pre_rst_irq", {31'h0, bus.irq}, 32'h1);
        read_check("pre_rst_status", A_STATUS, 32'h0000_0001);
        @(negedge hclk);
        bus.addr        = A_DATA;
        bus.wdata       = 32'h99;
        bus.byte_strobe = 4'hF;
        bus.write_en    = 1'b1;
        #2;
        hreset = 1'b1;
        #1;
        check("async_irq", {31'h0, bus.irq}, 32'h0);
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        bus.addr     = A_STATUS;
        #1;
        check("async_status", bus.rdata, 32'h0000_0010);
        bus.addr = A_CTRL;
        #1;
        check("async_ctrl", bus.rdata, 32'h0);
        @(posedge hclk);
        @(negedge hclk);
        hreset      = 1'b0;
        bus.read_en = 1'b0;
        read_check("post_rst_status", A_STATUS, 32'h0000_0010);
        bus_write(A_CTRL, 32'h1, 4'b0001);
        read_check("post_rst_pop", A_DATA, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reg_fifo_periph.md
REG_FIFO_PERIPH -- requirements
Module: reg_fifo_periph

Interface
REQ-001 SHALL have parameter ADDRWIDTH, default 12, register-interface address width.
REQ-002 SHALL have parameter DEPTH, default 8, FIFO entries; only 8 is supported.
REQ-003 SHALL have port hclk  input  1  single clock; all state is updated on the rising edge.
REQ-004 SHALL have port hreset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port addr  input  ADDRWIDTH  registered data-phase address from the AHB slave stage.
REQ-006 SHALL have port read_en  input  1  data-phase read strobe.
REQ-007 SHALL have port write_en  input  1  data-phase write strobe.
REQ-008 SHALL have port byte_strobe  input  4  byte lane enables; bit n covers wdata[8n+7:8n].
REQ-009 SHALL have port wdata  input  32  write data, valid while write_en=1.
REQ-010 SHALL have port rdata  output  32  read data, valid in the same cycle as read_en.
REQ-011 SHALL have port irq  output  1  registered, level interrupt.

Function
REQ-012 SHALL decode only addr[3:2]; all other address bits are ignored. Map: 0x0 DATA, 0x4 STATUS, 0x8 CTRL, 0xC reserved (reads 0, writes ignored).
REQ-013 SHALL drive rdata combinationally from addr and current state when read_en=1, and drive 0 when read_en=0.
REQ-014 SHALL treat read_en=1 with write_en=1 as a read only; the write is ignored.
REQ-015 DATA write SHALL push wdata into the FIFO, with unstrobed bytes stored as 0, only when CTRL.enable=1 and the FIFO is not full.
REQ-016 DATA write while full and enable=1 SHALL drop the data, leave the FIFO unchanged, and set STATUS.ovf.
REQ-017 DATA write while enable=0 SHALL be ignored and SHALL NOT set ovf.
REQ-018 DATA read with count>0 SHALL return the head entry and pop it at the clock edge ending that cycle.
REQ-019 DATA read when empty SHALL return 0, pop nothing, and set STATUS.udf.
REQ-020 FIFO SHALL use 3-bit read and write pointers wrapping 7->0 and a 4-bit count in the range 0..8.
REQ-021 STATUS read SHALL return: [3:0] count, [4] empty (count==0), [5] full (count==8), [8] ovf, [9] udf, all other bits 0.
REQ-022 STATUS write with byte_strobe[1]=1 SHALL clear ovf where wdata[8]=1 and clear udf where wdata[9]=1 (write-1-to-clear); all other STATUS bits are read-only.
REQ-023 CTRL SHALL hold: [0] enable, [1] irq_en, [7:4] thresh; bit [2] is flush, which is write-only and reads back 0.
REQ-024 CTRL bits [7:0] SHALL be written only when byte_strobe[0]=1.
REQ-025 A CTRL write with wdata[2]=1 and byte_strobe[0]=1 SHALL reset both pointers and count to 0 in the same edge; FIFO contents are don't-care; ovf and udf are unaffected.
REQ-026 irq SHALL be registered: irq(next) = irq_en & (ovf | udf | (thresh!=0 & count>=thresh)), evaluated on post-update state, so irq lags the causing access by exactly one cycle.
REQ-027 Sticky flags SHALL be set with priority over a W1C clear only when the set and the clear occur in the same cycle; this cannot occur with exclusive strobes but SHALL be coded so.

Reset
REQ-028 hreset=1 SHALL asynchronously clear pointers, count, ovf, udf, CTRL (enable=0, irq_en=0, thresh=0) and irq; rdata then follows REQ-013.
REQ-029 Reset asserted mid-transfer SHALL abort that transfer with no push or pop; operation resumes on the first edge after deassertion.
REQ-030 FIFO storage SHALL NOT require reset.

Verification
REQ-031 Reset, then read STATUS -> 0x00000010; read CTRL -> 0x0; irq=0.
REQ-032 Write CTRL=0x1, push 0xA1..0xA8 (8 words) -> STATUS=0x00000028; 9th push 0xA9 -> STATUS=0x00000128; pop 8 times returns 0xA1..0xA8 in order.
REQ-033 With empty FIFO, read DATA -> rdata=0, STATUS=0x00000210; write STATUS=0x200 with byte_strobe=4'b0010 -> STATUS=0x00000010.
REQ-034 Push 0x11223344 with byte_strobe=4'b0101 -> pop returns 0x00220044; interleave 12 pushes and pops -> pointer wrap verified, data order preserved.
REQ-035 CTRL=0x33 (enable, irq_en, thresh=3): push 3 words -> irq=1 in the cycle after the 3rd push; one pop -> irq=0 one cycle later; CTRL write of 0x37 -> count=0 next cycle.
REQ-036 Assert hreset during the data phase of a DATA write -> no entry stored and all state at reset values immediately, without waiting for a clock edge.
